// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings for the memory request arbiter: owner IDs, size codes and the
// request-field bundle that is muxed onto the shared port.
package mem_req_arbiter_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2
  } size_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_id_fifo.sv
// In-order owner-ID queue: 1-bit wide circular FIFO with head, full, empty and count.
module mem_req_id_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          push_id,
  input  logic          pop,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like port between instruction fetch and load/store, routing responses
// in order via an owner-ID queue. Define ARB_RR_EN for alternating tie-break priority.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        spurious_rsp
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [0:0]    state;
  logic          lock_id;
  logic          grant;
  logic          granted_req;
  logic          handshake;
  logic          q_head;
  logic          q_full;
  logic          q_empty;
  logic          q_pop;
  logic [CW-1:0] q_count;
  mem_req_t      inst_f;
  mem_req_t      data_f;
  mem_req_t      bus_f;

`ifdef ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!resetn)        last_grant <= ID_DATA;
    else if (handshake) last_grant <= grant;
  end
`endif

  // A locked grant is held until accepted so the request stays stable on the port.
  always_comb begin
    grant = ID_DATA;
    if (state == ST_LOCKED) grant = lock_id;
`ifdef ARB_RR_EN
    else if (inst_req && data_req) grant = ~last_grant;
    else if (inst_req) grant = ID_INST;
`else
    else if (!data_req && inst_req) grant = ID_INST;
`endif
  end

  assign granted_req = (grant == ID_DATA) ? data_req : inst_req;
  assign bus_req     = granted_req & ~q_full;
  assign handshake   = bus_req & bus_addr_ok;

  assign inst_addr_ok = handshake & (grant == ID_INST);
  assign data_addr_ok = handshake & (grant == ID_DATA);

  assign inst_f = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata};
  assign data_f = '{wr: data_wr, size: data_size, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};
  assign bus_f  = (grant == ID_DATA) ? data_f : inst_f;

  assign bus_wr    = bus_f.wr;
  assign bus_size  = bus_f.size;
  assign bus_wstrb = bus_f.wstrb;
  assign bus_addr  = bus_f.addr;
  assign bus_wdata = bus_f.wdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_UNLOCKED;
      lock_id <= ID_INST;
    end else begin
      case (state)
        ST_UNLOCKED: begin
          if (bus_req && !bus_addr_ok) begin
            state   <= ST_LOCKED;
            lock_id <= grant;
          end
        end
        ST_LOCKED: begin
          if (handshake || !granted_req) state <= ST_UNLOCKED;
        end
        default: state <= ST_UNLOCKED;
      endcase
    end
  end

  mem_req_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (handshake),
    .push_id (grant),
    .pop     (q_pop),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  // A response with nothing outstanding is flagged, never matched to a same-cycle request.
  assign q_pop        = bus_data_ok & ~q_empty;
  assign inst_data_ok = q_pop & (q_head == ID_INST);
  assign data_data_ok = q_pop & (q_head == ID_DATA);
  assign spurious_rsp = bus_data_ok & q_empty;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: arbitration, lock, full queue, routing, spurious responses.
module tb_mem_req_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] IADDR = 32'h1C00_0000;
  localparam logic [31:0] DADDR = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok, spurious_rsp;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.MAX_OUTSTANDING(2)) u_dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .spurious_rsp(spurious_rsp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    bit first_data;
    bit exp_data;
    bit prev_data;
    first_data = !RR;

    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_addr = IADDR; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0; data_addr = DADDR; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    cyc(); cyc();
    resetn = 1'b1;

    // Reset / idle
    smp();
    chk("idle_bus_req", bus_req, 0);
    chk("idle_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("idle_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("idle_spurious", spurious_rsp, 0);
    cyc(); cyc(); cyc();
    smp();
    chk("idle3_bus_req", bus_req, 0);
    cyc();

    // Both requesters, port ready immediately
    inst_req = 1; data_req = 1; bus_addr_ok = 1;
    smp();
    chk("both1_data_addr_ok", data_addr_ok, first_data);
    chk("both1_inst_addr_ok", inst_addr_ok, !first_data);
    chk("both1_bus_addr", bus_addr, first_data ? DADDR : IADDR);
    cyc();
    if (first_data) data_req = 0; else inst_req = 0;
    smp();
    chk("both2_inst_addr_ok", inst_addr_ok, first_data);
    chk("both2_data_addr_ok", data_addr_ok, !first_data);
    chk("both2_bus_addr", bus_addr, first_data ? IADDR : DADDR);
    cyc();
    inst_req = 0; data_req = 0; bus_addr_ok = 0;
    bus_data_ok = 1; bus_rdata = 32'h1111_1111;
    smp();
    chk("rsp1_data_data_ok", data_data_ok, first_data);
    chk("rsp1_inst_data_ok", inst_data_ok, !first_data);
    chk("rsp1_rdata", first_data ? data_rdata : inst_rdata, 32'h1111_1111);
    cyc();
    bus_rdata = 32'h2222_2222;
    smp();
    chk("rsp2_inst_data_ok", inst_data_ok, first_data);
    chk("rsp2_data_data_ok", data_data_ok, !first_data);
    chk("rsp2_rdata", first_data ? inst_rdata : data_rdata, 32'h2222_2222);
    cyc();
    bus_data_ok = 0;

    // Lock: inst waits for addr_ok, data arrives meanwhile
    inst_req = 1;
    smp();
    chk("lock_a_bus_req", bus_req, 1);
    chk("lock_a_bus_addr", bus_addr, IADDR);
    cyc();
    data_req = 1;
    smp();
    chk("lock_b_bus_addr", bus_addr, IADDR);
    chk("lock_b_data_addr_ok", data_addr_ok, 0);
    cyc();
    smp();
    chk("lock_c_bus_addr", bus_addr, IADDR);
    cyc();
    bus_addr_ok = 1;
    smp();
    chk("lock_d_inst_addr_ok", inst_addr_ok, 1);
    chk("lock_d_bus_addr", bus_addr, IADDR);
    chk("lock_d_data_addr_ok", data_addr_ok, 0);
    cyc();
    inst_req = 0;
    smp();
    chk("lock_e_data_addr_ok", data_addr_ok, 1);
    chk("lock_e_bus_addr", bus_addr, DADDR);
    cyc();
    data_req = 0;

    // Full queue (inst, data outstanding) with a third request pending
    inst_req = 1;
    smp();
    chk("full_bus_req", bus_req, 0);
    chk("full_inst_addr_ok", inst_addr_ok, 0);
    chk("full_count", 32'(u_dut.u_fifo.count), 2);
    cyc();
    bus_data_ok = 1; bus_rdata = 32'hA5A5_A5A5;
    smp();
    chk("full_pop_bus_req", bus_req, 0);
    chk("full_pop_inst_data_ok", inst_data_ok, 1);
    chk("full_pop_rdata", inst_rdata, 32'hA5A5_A5A5);
    cyc();
    bus_data_ok = 0;
    smp();
    chk("after_pop_bus_req", bus_req, 1);
    chk("after_pop_inst_addr_ok", inst_addr_ok, 1);
    cyc();
    inst_req = 0; bus_data_ok = 1; bus_rdata = 32'h3333_3333;
    smp();
    chk("drain1_data_data_ok", data_data_ok, 1);
    chk("drain1_inst_data_ok", inst_data_ok, 0);
    cyc();
    smp();
    chk("drain2_inst_data_ok", inst_data_ok, 1);
    chk("drain2_data_data_ok", data_data_ok, 0);
    cyc();
    bus_data_ok = 0;

    // Response with nothing outstanding
    smp();
    chk("drained_count", 32'(u_dut.u_fifo.count), 0);
    cyc();
    bus_data_ok = 1;
    smp();
    chk("spur_flag", spurious_rsp, 1);
    chk("spur_data_ok", {inst_data_ok, data_data_ok}, 0);
    cyc();
    bus_data_ok = 0;
    smp();
    chk("spur_clear", spurious_rsp, 0);
    chk("spur_count", 32'(u_dut.u_fifo.count), 0);
    cyc();

    // Fresh reset so the tie-break sequence starts from its reset state
    resetn = 0; cyc(); resetn = 1;
    inst_req = 1; data_req = 1; bus_addr_ok = 1;
    prev_data = 0;
    for (int k = 0; k < 4; k++) begin
      exp_data = RR ? (k % 2 == 1) : 1'b1;
      bus_data_ok = (k > 0);
      bus_rdata = 32'h4000_0000 + 32'(k);
      smp();
      chk($sformatf("stream%0d_data_addr_ok", k), data_addr_ok, exp_data);
      chk($sformatf("stream%0d_inst_addr_ok", k), inst_addr_ok, !exp_data);
      if (k > 0) chk($sformatf("stream%0d_data_data_ok", k), data_data_ok, prev_data);
      prev_data = exp_data;
      cyc();
    end

    // Reset with one ID outstanding discards it
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    resetn = 0; cyc(); resetn = 1;
    bus_data_ok = 1;
    smp();
    chk("rst_discard_spurious", spurious_rsp, 1);
    chk("rst_discard_data_ok", {inst_data_ok, data_data_ok}, 0);
    cyc();
    bus_data_ok = 0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
